// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Covers the RV32M funct3 codes, the FSM states and the divide-by-zero fill value.
package mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

  // Replicated across WIDTH for the DIV/DIVU quotient when the divisor is zero.
  localparam logic DIVZ_FILL = 1'b1;
endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result selection, applied to the unsigned core results.
// For divides, i_hi holds the remainder and i_lo holds the quotient.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_sa,
  input  logic             i_sb,
  output logic [WIDTH-1:0] o_y
);
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_prod   = {i_hi, i_lo};
  assign w_prod_s = (i_sa ^ i_sb) ? -w_prod : w_prod;
  assign w_quo    = (i_sa ^ i_sb) ? -i_lo : i_lo;
  assign w_rem    = i_sa ? -i_hi : i_hi;

  always_comb begin
    o_y = w_rem;
    case (i_op)
      OP_MUL:                      o_y = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_y = w_prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             o_y = w_quo;
      default:                     o_y = w_rem;
    endcase
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Operand magnitudes are iterated unsigned; signs are reapplied in the FIX cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic               r_sa, r_sb, r_dz;
  logic [WIDTH-1:0]   r_m, r_hi, r_lo, r_y;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sa_in, w_sb_in, w_div0, w_ovf, w_last, w_qbit;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_fix_y, w_rem_nxt;
  logic [WIDTH:0]     w_sum, w_shift, w_trial;

  always_comb begin
    w_sa_in = 1'b0;
    w_sb_in = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_sa_in = a[WIDTH-1];
        w_sb_in = b[WIDTH-1];
      end
      OP_MULHSU: w_sa_in = a[WIDTH-1];
      default: ;
    endcase
  end

  assign w_a_mag = w_sa_in ? -a : a;
  assign w_b_mag = w_sb_in ? -b : b;
  assign w_div0  = op[2] && (b == '0);
  assign w_ovf   = (op == OP_DIV || op == OP_REM) &&
                   (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign w_last  = (r_cnt == CNT_W'(WIDTH-1));

  // Multiply: r_hi accumulates, r_lo shifts the multiplier out and the product low bits in.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_m};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .i_op (r_op),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .i_sa (r_sa),
    .i_sb (r_sb),
    .o_y  (w_fix_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = (w_div0 || w_ovf) ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_dz  <= 1'b0;
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op  <= op;
          r_sa  <= w_sa_in;
          r_sb  <= w_sb_in;
          r_cnt <= '0;
          r_hi  <= '0;
          r_m   <= op[2] ? w_b_mag : w_a_mag;
          r_lo  <= op[2] ? w_a_mag : w_b_mag;
          r_dz  <= w_div0;
          if (w_div0)     r_y <= op[1] ? a : {WIDTH{DIVZ_FILL}};
          else if (w_ovf) r_y <= op[1] ? '0 : a;
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_hi <= w_rem_nxt;
            r_lo <= {r_lo[WIDTH-2:0], w_qbit};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        ST_FIX: r_y <= w_fix_y;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_y;
  assign div_zero  = r_dz;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit that implements the RV32M operations next to the combinational ALU.
- Accepts one operation through a valid/ready input handshake.
- Computes it over WIDTH cycles (shift-add for multiply, restoring for divide), then holds the result under a valid/ready output handshake.
- Sits in the execute stage; the core stalls while in_ready is low or the result is pending.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operation request
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  WIDTH  rs1 operand
b  in  WIDTH  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer takes result
y  out  WIDTH  result
div_zero  out  1  flag, valid with out_valid: divide/rem by zero occurred

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, y=0, div_zero=0, counter=0, internal regs=0. Reset mid-operation aborts it; no result is produced.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid at a clock edge:
  - latch op, a, b; compute operand signs and magnitudes per op;
  - clear counter; go to CALC.
  - Special cases go straight to DONE with y loaded at the same edge.
- Special cases:
  - Divide by zero (b==0, op 1xx): DIV/DIVU y=all ones; REM/REMU y=a; div_zero=1.
  - Signed overflow (op 100/110, a=100..0, b=all ones): DIV y=a; REM y=0; div_zero=0.
- CALC: one iteration per cycle for exactly WIDTH cycles; the counter runs 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit product of unsigned magnitudes via shift-add.
  - Divide: restoring on magnitudes; each cycle shift one quotient bit in and keep the partial remainder.
- FIX: one cycle. Apply signs, then select the output and go to DONE:
  - product negated if signs differ (MULH signed*signed, MULHSU signed*unsigned, MULHU/MUL no sign on magnitude path);
  - quotient negated if dividend sign != divisor sign (DIV only);
  - remainder takes the dividend sign (REM only);
  - MUL=low WIDTH bits; MULH*=high WIDTH bits; DIV*=quotient; REM*=remainder.
- DONE: out_valid=1; y and div_zero stable. When out_ready=1 at an edge, go to IDLE and clear out_valid.
  - in_ready stays 0 in DONE; no new op is accepted in the same cycle the result is consumed.
- Latency: accept edge E0 -> out_valid high after edge E0+WIDTH+1. Special cases: high after E0+1.
- Throughput: one op per WIDTH+3 cycles minimum (accept, WIDTH CALC, FIX, DONE with out_ready=1).
- Inputs a, b, op are ignored outside the accepting edge; changes during CALC have no effect.
- in_valid held high while busy: not accepted until IDLE.
- out_ready high while out_valid=0: no effect.

Decomposition:
- Shared package (mdu_pkg): the op encodings as localparams (OP_MUL..OP_REMU), FSM state encodings (ST_IDLE, ST_CALC, ST_FIX, ST_DONE), and the division-by-zero result constant.
- Natural sub-module: mdu_sign_fix (combinational). Takes raw product/quotient/remainder, sign flags and op; returns the final y. Used in FIX.
- The iteration datapath and FSM stay in mdu_iter.

Test Plan:
- MUL 3*6, then MULHU 0xFFFFFFFF*0xFFFFFFFF (WIDTH=32) -> y=0x00000012; then y=0xFFFFFFFE. out_valid exactly 33 edges after accept.
- MULH 0x80000000*0x80000000 -> y=0x40000000. MULHSU 0xFFFFFFFF(-1)*0x00000002 -> y=0xFFFFFFFF.
- DIV -7/2 -> y=0xFFFFFFFD (-3). REM -7/2 -> y=0xFFFFFFFF (-1). DIVU 7/2 -> 3. REMU 7/2 -> 1.
- DIVU 5/0 -> y=0xFFFFFFFF, div_zero=1, out_valid after 1 edge. REM 5/0 -> y=5. DIV 0x80000000/0xFFFFFFFF -> y=0x80000000, div_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> y stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next edge, then the pending in_valid is accepted.
- Assert rst_n=0 mid-CALC (counter=10) -> out_valid=0, in_ready=1, y=0 immediately without a clock edge. Next op after release completes correctly.
